// File: rtl/fir_ctrl_pkg.sv
// Shared types and register-map helpers for the FIR sequencing controller.
package fir_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_COPY  = 3'd1,
    OP_LOAD1 = 3'd2,
    OP_LOAD2 = 3'd3,
    OP_ADD   = 3'd4,
    OP_SUB   = 3'd5,
    OP_MUL   = 3'd6
  } fir_op_t;

  // SHIFT, MUL and ACC are each a family of states indexed by a separate step register
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOADC,
    ST_STORE,
    ST_SHIFT,
    ST_ZERO,
    ST_MUL,
    ST_ACC,
    ST_EIDLE
  } fir_state_t;

  localparam int ACC_REG = 0;

  function automatic int sample_reg(input int k);
    return k;
  endfunction

  function automatic int coeff_reg(input int taps, input int i);
    return taps + 1 + i;
  endfunction

  function automatic int temp_reg(input int taps);
    return 2 * taps + 1;
  endfunction

  function automatic int incoming_reg(input int taps);
    return 2 * taps + 2;
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Wrapping up-counter; returns to zero on the enabled cycle after reaching rollover_val.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (count_enable) begin
      if (count_out == rollover_val) count_out <= '0;
      else                           count_out <= count_out + 1'b1;
    end
  end

endmodule

// File: rtl/fir_controller.sv
// Sequencing FSM driving the FIR datapath register file.
// Define FIR_ALT_SIGN_EN to subtract (rather than add) the odd-indexed products.
module fir_controller
  import fir_ctrl_pkg::*;
#(
  parameter int NUM_SEL_BITS = 4,
  parameter int NUM_TAPS     = 4
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic                    data_ready,
  input  logic                    load_coeff,
  input  logic                    overflow,
  output logic [2:0]              op,
  output logic [NUM_SEL_BITS-1:0] src1,
  output logic [NUM_SEL_BITS-1:0] src2,
  output logic [NUM_SEL_BITS-1:0] dest,
  output logic                    modwait,
  output logic                    cnt_up,
  output logic                    err
);

  localparam logic [NUM_SEL_BITS-1:0] TAPS_SEL   = NUM_SEL_BITS'(NUM_TAPS);
  localparam logic [NUM_SEL_BITS-1:0] LAST_TAP   = NUM_SEL_BITS'(NUM_TAPS - 1);
  localparam logic [NUM_SEL_BITS-1:0] ONE_SEL    = NUM_SEL_BITS'(1);
  localparam logic [NUM_SEL_BITS-1:0] ACC_SEL    = NUM_SEL_BITS'(ACC_REG);
  localparam logic [NUM_SEL_BITS-1:0] COEFF_BASE = NUM_SEL_BITS'(coeff_reg(NUM_TAPS, 0));
  localparam logic [NUM_SEL_BITS-1:0] TEMP_SEL   = NUM_SEL_BITS'(temp_reg(NUM_TAPS));
  localparam logic [NUM_SEL_BITS-1:0] IN_SEL     = NUM_SEL_BITS'(incoming_reg(NUM_TAPS));
  localparam logic [NUM_SEL_BITS-1:0] SAMPLE1    = NUM_SEL_BITS'(sample_reg(1));

  fir_state_t              state, next_state;
  logic [NUM_SEL_BITS-1:0] step, next_step;
  logic [NUM_SEL_BITS-1:0] coeff_idx;
  logic                    coeff_hold;
  logic                    next_busy;
  fir_op_t                 op_c;

  flex_counter #(
    .NUM_CNT_BITS(NUM_SEL_BITS)
  ) u_coeff_cnt (
    .clk         (clk),
    .n_rst       (n_reset),
    .count_enable(state == ST_LOADC),
    .rollover_val(LAST_TAP),
    .count_out   (coeff_idx)
  );

  // coeff_hold stops a still-high load_coeff from re-triggering LOADC after the load
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state      <= ST_IDLE;
      step       <= '0;
      modwait    <= 1'b0;
      coeff_hold <= 1'b0;
    end else begin
      state   <= next_state;
      step    <= next_step;
      modwait <= next_busy;
      if (state == ST_LOADC)  coeff_hold <= 1'b1;
      else if (!load_coeff)   coeff_hold <= 1'b0;
    end
  end

  always_comb begin
    next_state = state;
    next_step  = step;
    case (state)
      ST_IDLE, ST_EIDLE: begin
        if (load_coeff) begin
          if (!coeff_hold) next_state = ST_LOADC;
        end else if (data_ready) begin
          next_state = ST_STORE;
        end
      end
      ST_LOADC: next_state = ST_IDLE;
      ST_STORE: begin
        if (!data_ready) begin
          next_state = ST_EIDLE;
        end else begin
          next_state = ST_SHIFT;
          next_step  = TAPS_SEL;
        end
      end
      ST_SHIFT: begin
        if (step == ONE_SEL) begin
          next_state = ST_ZERO;
          next_step  = '0;
        end else begin
          next_step = step - 1'b1;
        end
      end
      ST_ZERO: begin
        next_state = ST_MUL;
        next_step  = '0;
      end
      ST_MUL: next_state = overflow ? ST_EIDLE : ST_ACC;
      ST_ACC: begin
        if (overflow) begin
          next_state = ST_EIDLE;
        end else if (step == LAST_TAP) begin
          next_state = ST_IDLE;
        end else begin
          next_state = ST_MUL;
          next_step  = step + 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
    next_busy = (next_state != ST_IDLE) && (next_state != ST_EIDLE) &&
                (next_state != ST_LOADC);
  end

  always_comb begin
    op_c   = OP_NOP;
    src1   = '0;
    src2   = '0;
    dest   = '0;
    cnt_up = 1'b0;
    err    = 1'b0;
    case (state)
      ST_LOADC: begin
        op_c = OP_LOAD2;
        dest = COEFF_BASE + coeff_idx;
      end
      ST_STORE: begin
        op_c = OP_LOAD1;
        dest = IN_SEL;
      end
      ST_SHIFT: begin
        op_c = OP_COPY;
        src1 = (step > ONE_SEL) ? step - 1'b1 : IN_SEL;
        dest = step;
      end
      ST_ZERO: begin
        op_c = OP_SUB;
        src1 = ACC_SEL;
        src2 = ACC_SEL;
        dest = ACC_SEL;
      end
      ST_MUL: begin
        op_c = OP_MUL;
        src1 = SAMPLE1 + step;
        src2 = COEFF_BASE + step;
        dest = TEMP_SEL;
      end
      ST_ACC: begin
`ifdef FIR_ALT_SIGN_EN
        op_c = step[0] ? OP_SUB : OP_ADD;
`else
        op_c = OP_ADD;
`endif
        src1   = ACC_SEL;
        src2   = TEMP_SEL;
        dest   = ACC_SEL;
        cnt_up = (step == LAST_TAP);
      end
      ST_EIDLE: err = 1'b1;
      default: ;
    endcase
  end

  assign op = op_c;

endmodule

// File: tb/tb_fir_controller.sv
// Self-checking bench for fir_controller: scoreboarded command trace plus a small datapath model.
module tb_fir_controller;

  localparam int SB = 4;
  localparam int T  = 4;

  typedef logic [17:0] expv_t;
  typedef struct {
    logic  dr;
    logic  lc;
    int    bus;
    expv_t exp;
    string name;
  } vec_t;

  logic          clk = 1'b0;
  logic          n_reset;
  logic          data_ready;
  logic          load_coeff;
  logic          overflow;
  logic [2:0]    op;
  logic [SB-1:0] src1;
  logic [SB-1:0] src2;
  logic [SB-1:0] dest;
  logic          modwait;
  logic          cnt_up;
  logic          err;

  expv_t exp_q[$];
  string name_q[$];
  int    checks     = 0;
  int    failures   = 0;
  int    dp[16];
  int    mw_cycles  = 0;
  int    cnt_pulses = 0;
  vec_t  vecs[$];

  always #5 clk = ~clk;

  fir_controller #(
    .NUM_SEL_BITS(SB),
    .NUM_TAPS    (T)
  ) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .data_ready(data_ready),
    .load_coeff(load_coeff),
    .overflow  (overflow),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .dest      (dest),
    .modwait   (modwait),
    .cnt_up    (cnt_up),
    .err       (err)
  );

  function automatic expv_t mk(input int o, input int s1, input int s2, input int d,
                               input logic mw, input logic cu, input logic er);
    return {3'(o), 4'(s1), 4'(s2), 4'(d), mw, cu, er};
  endfunction

  function automatic expv_t exp_idle();         return mk(0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic expv_t exp_eidle();        return mk(0, 0, 0, 0, 0, 0, 1); endfunction
  function automatic expv_t exp_loadc(int idx); return mk(3, 0, 0, T + 1 + idx, 0, 0, 0); endfunction
  function automatic expv_t exp_store();        return mk(2, 0, 0, 2 * T + 2, 1, 0, 0); endfunction
  function automatic expv_t exp_zero();         return mk(5, 0, 0, 0, 1, 0, 0); endfunction
  function automatic expv_t exp_shift(int k);
    return mk(1, (k > 1) ? k - 1 : 2 * T + 2, 0, k, 1, 0, 0);
  endfunction
  function automatic expv_t exp_mul(int i);
    return mk(6, i + 1, T + 1 + i, 2 * T + 1, 1, 0, 0);
  endfunction
  function automatic expv_t exp_acc(int i);
    int o;
`ifdef FIR_ALT_SIGN_EN
    o = (i % 2 == 1) ? 5 : 4;
`else
    o = 4;
`endif
    return mk(o, 0, 2 * T + 1, 0, 1, (i == T - 1), 0);
  endfunction

  task automatic checkValue(input string name, input int act, input int expd);
    checks++;
    if (act != expd) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expd);
    end
  endtask

  task automatic checkOutput();
    expv_t act;
    expv_t e;
    string n;
    act = {op, src1, src2, dest, modwait, cnt_up, err};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_empty: got %h, expected nothing", act);
      return;
    end
    e = exp_q.pop_front();
    n = name_q.pop_front();
    if (act !== e) begin
      failures++;
      $display("[TB] FAIL %s: got op=%0d src1=%0d src2=%0d dest=%0d mw=%b cu=%b err=%b, expected op=%0d src1=%0d src2=%0d dest=%0d mw=%b cu=%b err=%b",
               n, act[17:15], act[14:11], act[10:7], act[6:3], act[2], act[1], act[0],
               e[17:15], e[14:11], e[10:7], e[6:3], e[2], e[1], e[0]);
    end
  endtask

  task automatic checkZero(input string name);
    checks++;
    if ({op, src1, src2, dest, modwait, cnt_up, err} !== 18'd0) begin
      failures++;
      $display("[TB] FAIL %s: got op=%0d src1=%0d src2=%0d dest=%0d mw=%b cu=%b err=%b, expected all zero",
               name, op, src1, src2, dest, modwait, cnt_up, err);
    end
  endtask

  // datapath model executes the command visible during the cycle, committing at the edge
  task automatic execModel(input int bus);
    case (op)
      3'd1:       dp[dest] = dp[src1];
      3'd2, 3'd3: dp[dest] = bus;
      3'd4:       dp[dest] = dp[src1] + dp[src2];
      3'd5:       dp[dest] = dp[src1] - dp[src2];
      3'd6:       dp[dest] = dp[src1] * dp[src2];
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input logic dr, input logic lc, input logic ov, input int bus,
                               input expv_t e, input string name);
    exp_q.push_back(e);
    name_q.push_back(name);
    data_ready = dr;
    load_coeff = lc;
    overflow   = ov;
    execModel(bus);
    @(posedge clk);
    #1;
    if (modwait) mw_cycles++;
    if (cnt_up)  cnt_pulses++;
    checkOutput();
  endtask

  // one sample pass; ovf_acc>=0 raises overflow in that ACC state, stop_mul>=0 halts after that MUL
  task automatic runPass(input int sample, input int ovf_acc, input int stop_mul, input bit full_check);
    mw_cycles  = 0;
    cnt_pulses = 0;
    applyStimulus(1, 0, 0, sample, exp_store(), "store");
    applyStimulus(1, 0, 0, sample, exp_shift(T), $sformatf("shift_%0d", T));
    for (int k = T - 1; k >= 1; k--)
      applyStimulus(0, 0, 0, sample, exp_shift(k), $sformatf("shift_%0d", k));
    applyStimulus(0, 0, 0, sample, exp_zero(), "zero");
    for (int i = 0; i < T; i++) begin
      applyStimulus(0, 0, 0, sample, exp_mul(i), $sformatf("mul_%0d", i));
      if (i == stop_mul) return;
      applyStimulus(0, 0, 0, sample, exp_acc(i), $sformatf("acc_%0d", i));
      if (i == ovf_acc) begin
        applyStimulus(0, 0, 1, sample, exp_eidle(), "ovf_eidle");
        checkValue("ovf_no_cnt_up", cnt_pulses, 0);
        return;
      end
    end
    applyStimulus(0, 0, 0, sample, exp_idle(), "pass_done_idle");
    if (full_check) begin
      checkValue("modwait_cycles", mw_cycles, 3 * T + 2);
      checkValue("cnt_up_pulses", cnt_pulses, 1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int r = 0; r < 16; r++) dp[r] = 0;
    // five one-cycle load_coeff pulses with two idle cycles each; the fifth wraps to F0
    for (int p = 0; p < 5; p++) begin
      vecs.push_back('{dr: 1'b0, lc: 1'b1, bus: (p % T) + 1, exp: exp_loadc(p % T),
                       name: $sformatf("loadc_%0d", p)});
      vecs.push_back('{dr: 1'b0, lc: 1'b0, bus: (p % T) + 1, exp: exp_idle(),
                       name: $sformatf("gap_a_%0d", p)});
      vecs.push_back('{dr: 1'b0, lc: 1'b0, bus: (p % T) + 1, exp: exp_idle(),
                       name: $sformatf("gap_b_%0d", p)});
    end

    n_reset    = 1'b0;
    data_ready = 1'b0;
    load_coeff = 1'b0;
    overflow   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkZero("reset_state");
    @(negedge clk);
    n_reset = 1'b1;
    @(posedge clk);
    #1;
    checkZero("after_reset_idle");

    foreach (vecs[v])
      applyStimulus(vecs[v].dr, vecs[v].lc, 1'b0, vecs[v].bus, vecs[v].exp, vecs[v].name);

    runPass(10, -1, -1, 1'b1);
    checkValue("reg0_sample10", dp[0], 10);

    runPass(20, -1, -1, 1'b1);
`ifdef FIR_ALT_SIGN_EN
    checkValue("reg0_sample20", dp[0], 20 * 1 - 10 * 2);
`else
    checkValue("reg0_sample20", dp[0], 20 * 1 + 10 * 2);
`endif

    runPass(30, 2, -1, 1'b0);
    runPass(35, -1, -1, 1'b1);

    // both strobes together: coefficient load wins, sample follows; then abort in STORE
    applyStimulus(1, 1, 0, 0, exp_loadc(1), "prio_loadc");
    applyStimulus(1, 0, 0, 0, exp_idle(), "prio_idle");
    applyStimulus(1, 0, 0, 0, exp_store(), "prio_store");
    applyStimulus(0, 0, 0, 0, exp_eidle(), "store_abort_eidle");
    applyStimulus(0, 0, 0, 0, exp_eidle(), "eidle_hold");

    runPass(50, -1, 1, 1'b0);
    #3;
    n_reset = 1'b0;
    #1;
    checkZero("reset_mid_pass");
    @(posedge clk);
    #1;
    checkZero("reset_held");
    @(negedge clk);
    n_reset = 1'b1;
    @(posedge clk);
    #1;
    checkZero("reset_release_idle");
    applyStimulus(0, 1, 0, 9, exp_loadc(0), "idx_cleared_by_reset");
    applyStimulus(0, 0, 0, 9, exp_idle(), "idx_cleared_idle");

    checkValue("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
